// File: rtl/seed_random_4_card_dealer_pkg.sv
// ---------------------------------------------------------------------------
// seed_random_4_card_dealer_pkg
//
// Shared definitions for the seed-random card dealer:
//   - default shoe geometry (cards per deck, decks per shoe)
//   - dealer FSM state encoding (IDLE = 1'b0, SCAN = 1'b1)
//   - width helper: ceil(log2(n)) with a floor of one bit, so that a
//     single-deck shoe still has a 1-bit deck index
// No ports; imported by the dealer top and its position counter.
// ---------------------------------------------------------------------------
package seed_random_4_card_dealer_pkg;

  localparam int unsigned DEF_DECK_SIZE = 52;
  localparam int unsigned DEF_NUM_DECKS = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seed_random_4_pos_counter.sv
// ---------------------------------------------------------------------------
// seed_random_4_pos_counter
//
// (deck, card) wrap counter. The card field wraps DECK_SIZE-1 -> 0 and
// carries into the deck field, which wraps NUM_DECKS-1 -> 0, so the pair
// walks every shoe slot in order and returns to (0,0).
//
// Ports:
//   clk_i        in   rising-edge clock
//   rst_ni       in   asynchronous active-low reset, counter -> (0,0)
//   en_i         in   advance one slot this cycle
//   load_i       in   synchronous load of (load_deck_i, load_card_i);
//                     takes priority over en_i
//   load_deck_i  in   deck value to load
//   load_card_i  in   card value to load
//   deck_o       out  current deck index
//   card_o       out  current card index
// ---------------------------------------------------------------------------
module seed_random_4_pos_counter
  import seed_random_4_card_dealer_pkg::*;
#(
  parameter int unsigned DECK_SIZE = DEF_DECK_SIZE,
  parameter int unsigned NUM_DECKS = DEF_NUM_DECKS,
  parameter int unsigned CW        = $clog2(DECK_SIZE),
  parameter int unsigned DW        = min1_clog2(NUM_DECKS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [DW-1:0] load_deck_i,
  input  logic [CW-1:0] load_card_i,
  output logic [DW-1:0] deck_o,
  output logic [CW-1:0] card_o
);

  localparam logic [CW-1:0] CARD_LAST = CW'(DECK_SIZE - 1);
  localparam logic [DW-1:0] DECK_LAST = DW'(NUM_DECKS - 1);

  logic [CW-1:0] card_q, card_d;
  logic [DW-1:0] deck_q, deck_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    card_d = card_q;
    deck_d = deck_q;
    if (load_i) begin
      card_d = load_card_i;
      deck_d = load_deck_i;
    end else if (en_i) begin
      if (card_q == CARD_LAST) begin
        card_d = '0;
        deck_d = (deck_q == DECK_LAST) ? '0 : deck_q + DW'(1);
      end else begin
        card_d = card_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_ni) begin
      card_q <= '0;
      deck_q <= '0;
    end else begin
      card_q <= card_d;
      deck_q <= deck_d;
    end
  end

  assign deck_o = deck_q;
  assign card_o = card_q;

endmodule

// File: rtl/seed_random_4_card_dealer.sv
// ---------------------------------------------------------------------------
// seed_random_4_card_dealer
//
// Deals cards from a multi-deck shoe without replacement. A free-running
// (deck, card) position counter provides timing entropy while run_i is high.
// A request copies the current position into a scan pointer, which walks
// forward past already-dealt slots until it finds a free one; that slot is
// marked dealt and reported.
//
// Ports:
//   clk_dp_c_i    in   clock, all state on rising edge
//   rst_dp_c_i    in   asynchronous active-low reset
//   run_i         in   position counter advances one slot per cycle
//   req_i         in   deal request, sampled only in IDLE
//   shuffle_i     in   clear dealt bitmap and refill shoe (aborts a scan)
//   card_o        out  last dealt card index, 0..DECK_SIZE-1
//   deck_o        out  deck of last dealt card, 0..NUM_DECKS-1
//   card_valid_o  out  one-cycle pulse, card_o/deck_o freshly dealt
//   busy_o        out  high while scanning
//   empty_o       out  no undealt cards remain
//   err_empty_o   out  one-cycle pulse, request refused on an empty shoe
//   remaining_o   out  number of undealt cards
// ---------------------------------------------------------------------------
module seed_random_4_card_dealer
  import seed_random_4_card_dealer_pkg::*;
#(
  parameter int unsigned DECK_SIZE = DEF_DECK_SIZE,
  parameter int unsigned NUM_DECKS = DEF_NUM_DECKS,
  parameter int unsigned TOTAL     = DECK_SIZE * NUM_DECKS,
  parameter int unsigned CW        = $clog2(DECK_SIZE),
  parameter int unsigned DW        = min1_clog2(NUM_DECKS),
  parameter int unsigned RW        = $clog2(TOTAL + 1)
) (
  input  logic          clk_dp_c_i,
  input  logic          rst_dp_c_i,
  input  logic          run_i,
  input  logic          req_i,
  input  logic          shuffle_i,
  output logic [CW-1:0] card_o,
  output logic [DW-1:0] deck_o,
  output logic          card_valid_o,
  output logic          busy_o,
  output logic          empty_o,
  output logic          err_empty_o,
  output logic [RW-1:0] remaining_o
);

  localparam int unsigned SW = min1_clog2(TOTAL);

  state_e           state_q;
  logic [TOTAL-1:0] bitmap_q;
  logic [RW-1:0]    remaining_q, remaining_d;
  logic [CW-1:0]    card_q;
  logic [DW-1:0]    deck_q;
  logic             card_valid_q;
  logic             err_empty_q;
  logic             empty_q;

  logic [DW-1:0]    pos_deck, ptr_deck;
  logic [CW-1:0]    pos_card, ptr_card;
  logic [SW-1:0]    ptr_slot;
  logic             slot_taken;
  logic             start_scan, refuse, deal, step;

  // Free-running entropy source.
  seed_random_4_pos_counter #(
    .DECK_SIZE (DECK_SIZE),
    .NUM_DECKS (NUM_DECKS),
    .CW        (CW),
    .DW        (DW)
  ) u_pos (
    .clk_i       (clk_dp_c_i),
    .rst_ni      (rst_dp_c_i),
    .en_i        (run_i),
    .load_i      (1'b0),
    .load_deck_i ('0),
    .load_card_i ('0),
    .deck_o      (pos_deck),
    .card_o      (pos_card)
  );

  // Scan pointer: loaded with the pre-edge position on request, then
  // stepped past each dealt slot.
  seed_random_4_pos_counter #(
    .DECK_SIZE (DECK_SIZE),
    .NUM_DECKS (NUM_DECKS),
    .CW        (CW),
    .DW        (DW)
  ) u_ptr (
    .clk_i       (clk_dp_c_i),
    .rst_ni      (rst_dp_c_i),
    .en_i        (step),
    .load_i      (start_scan),
    .load_deck_i (pos_deck),
    .load_card_i (pos_card),
    .deck_o      (ptr_deck),
    .card_o      (ptr_card)
  );

  assign ptr_slot   = SW'(32'(ptr_deck) * DECK_SIZE + 32'(ptr_card));
  assign slot_taken = bitmap_q[ptr_slot];

  // Shuffle outranks everything in both states.
  assign refuse     = (state_q == ST_IDLE) && !shuffle_i && req_i && (remaining_q == '0);
  assign start_scan = (state_q == ST_IDLE) && !shuffle_i && req_i && (remaining_q != '0);
  assign deal       = (state_q == ST_SCAN) && !shuffle_i && !slot_taken;
  assign step       = (state_q == ST_SCAN) && !shuffle_i &&  slot_taken;

  // Next remaining count; empty_o is registered from this so it changes on
  // the same edge as remaining_o rather than one cycle later.
  always_comb begin
    remaining_d = remaining_q;
    if (shuffle_i) begin
      remaining_d = RW'(TOTAL);
    end else if (deal) begin
      remaining_d = remaining_q - RW'(1);
    end
  end

  always_ff @(posedge clk_dp_c_i or negedge rst_dp_c_i) begin
    if (!rst_dp_c_i) begin
      state_q      <= ST_IDLE;
      // NOTE: the dealt bitmap is reset because its contents are
      // architectural: a stale bit would silently remove a card from play.
      bitmap_q     <= '0;
      remaining_q  <= RW'(TOTAL);
      empty_q      <= 1'b0;
      card_q       <= '0;
      deck_q       <= '0;
      card_valid_q <= 1'b0;
      err_empty_q  <= 1'b0;
    end else begin
      card_valid_q <= 1'b0;
      err_empty_q  <= 1'b0;
      remaining_q  <= remaining_d;
      empty_q      <= (remaining_d == '0);

      case (state_q)
        ST_IDLE: begin
          if (shuffle_i) begin
            bitmap_q <= '0;
          end else if (refuse) begin
            err_empty_q <= 1'b1;
          end else if (start_scan) begin
            state_q <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (shuffle_i) begin
            bitmap_q <= '0;
            state_q  <= ST_IDLE;
          end else if (deal) begin
            bitmap_q[ptr_slot] <= 1'b1;
            card_q             <= ptr_card;
            deck_q             <= ptr_deck;
            card_valid_q       <= 1'b1;
            state_q            <= ST_IDLE;
          end
          // Otherwise the pointer steps (see u_ptr.en_i). Entry requires
          // remaining > 0, so a free slot is always reached.
        end
      endcase
    end
  end

  assign card_o       = card_q;
  assign deck_o       = deck_q;
  assign card_valid_o = card_valid_q;
  assign busy_o       = (state_q == ST_SCAN);
  assign empty_o      = empty_q;
  assign err_empty_o  = err_empty_q;
  assign remaining_o  = remaining_q;

endmodule

// File: tb/tb_seed_random_4_card_dealer.sv
// ---------------------------------------------------------------------------
// tb_seed_random_4_card_dealer
//
// Directed bench with two dealers on one clock: dut_a (52 cards, 1 deck) and
// dut_b (4 cards, 2 decks). Expected cards, latencies and counts are worked
// out by hand from the dealing rules and written as constants below.
// ---------------------------------------------------------------------------
module tb_seed_random_4_card_dealer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       run_a, req_a, shuffle_a;
  logic [5:0] card_a;
  logic [0:0] deck_a;
  logic       valid_a, busy_a, empty_a, err_a;
  logic [5:0] rem_a;

  logic       run_b, req_b, shuffle_b;
  logic [1:0] card_b;
  logic [0:0] deck_b;
  logic       valid_b, busy_b, empty_b, err_b;
  logic [3:0] rem_b;

  int n_checks = 0;
  int n_errors = 0;

  seed_random_4_card_dealer dut_a (
    .clk_dp_c_i   (clk),
    .rst_dp_c_i   (rst_n),
    .run_i        (run_a),
    .req_i        (req_a),
    .shuffle_i    (shuffle_a),
    .card_o       (card_a),
    .deck_o       (deck_a),
    .card_valid_o (valid_a),
    .busy_o       (busy_a),
    .empty_o      (empty_a),
    .err_empty_o  (err_a),
    .remaining_o  (rem_a)
  );

  seed_random_4_card_dealer #(
    .DECK_SIZE (4),
    .NUM_DECKS (2)
  ) dut_b (
    .clk_dp_c_i   (clk),
    .rst_dp_c_i   (rst_n),
    .run_i        (run_b),
    .req_i        (req_b),
    .shuffle_i    (shuffle_b),
    .card_o       (card_b),
    .deck_o       (deck_b),
    .card_valid_o (valid_b),
    .busy_o       (busy_b),
    .empty_o      (empty_b),
    .err_empty_o  (err_b),
    .remaining_o  (rem_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Output selectors: s=0 -> dut_a, s=1 -> dut_b.
  function automatic int o_card(input bit s);  return s ? int'(card_b)  : int'(card_a);  endfunction
  function automatic int o_deck(input bit s);  return s ? int'(deck_b)  : int'(deck_a);  endfunction
  function automatic int o_rem(input bit s);   return s ? int'(rem_b)   : int'(rem_a);   endfunction
  function automatic bit o_valid(input bit s); return s ? valid_b : valid_a; endfunction
  function automatic bit o_busy(input bit s);  return s ? busy_b  : busy_a;  endfunction
  function automatic bit o_err(input bit s);   return s ? err_b   : err_a;   endfunction

  task automatic set_req(input bit s, input logic v);
    if (s) req_b = v;
    else   req_a = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request pulse, then watch (bounded) for a valid or error
  // pulse. lat counts samples after the sampling edge: 1 = right after it.
  task automatic deal(input bit s, output int card, output int deck, output int lat,
                      output int busy_cyc, output bit got, output bit saw_err);
    card = 0; deck = 0; lat = 0; busy_cyc = 0; got = 1'b0; saw_err = 1'b0;
    set_req(s, 1'b1);
    tick();
    set_req(s, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      if (o_valid(s)) begin
        got = 1'b1; lat = i; card = o_card(s); deck = o_deck(s);
        break;
      end
      if (o_busy(s)) busy_cyc++;
      if (o_err(s)) begin
        saw_err = 1'b1; lat = i;
        break;
      end
      tick();
    end
  endtask

  task automatic expect_deal(input bit s, input string tag, input int e_card, input int e_deck,
                             input int e_lat, input int e_rem);
    int c, d, l, bc;
    bit g, e;
    deal(s, c, d, l, bc, g, e);
    check({tag, "_got"},  32'(g), 32'd1);
    check({tag, "_card"}, c, e_card);
    check({tag, "_deck"}, d, e_deck);
    check({tag, "_lat"},  l, e_lat);
    check({tag, "_busy"}, bc, e_lat - 1);
    check({tag, "_rem"},  o_rem(s), e_rem);
  endtask

  task automatic run_cycles(input bit s, input int n);
    if (s) run_b = 1'b1; else run_a = 1'b1;
    repeat (n) tick();
    if (s) run_b = 1'b0; else run_a = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit [7:0] seen;
    bit       any_valid;
    int       c, d, l, bc;
    bit       g, e;

    run_a = 1'b0; req_a = 1'b0; shuffle_a = 1'b0;
    run_b = 1'b0; req_b = 1'b0; shuffle_b = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();

    // Reset values.
    check("rst_a_card",  card_a,  0);
    check("rst_a_deck",  deck_a,  0);
    check("rst_a_valid", valid_a, 0);
    check("rst_a_busy",  busy_a,  0);
    check("rst_a_empty", empty_a, 0);
    check("rst_a_err",   err_a,   0);
    check("rst_a_rem",   rem_a,   52);
    check("rst_b_rem",   rem_b,   8);

    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---- dut_a: 52 x 1 ----
    expect_deal(1'b0, "a_first", 0, 0, 2, 51);
    run_cycles(1'b0, 5);
    expect_deal(1'b0, "a_card5", 5, 0, 2, 50);
    // A full lap of 52 brings the counter back to slot 5, which is taken.
    run_cycles(1'b0, 52);
    expect_deal(1'b0, "a_skip", 6, 0, 3, 49);

    // Shuffle and request together in IDLE: only the shuffle acts.
    shuffle_a = 1'b1; req_a = 1'b1;
    tick();
    shuffle_a = 1'b0; req_a = 1'b0;
    check("a_shreq_busy",  busy_a,  0);
    check("a_shreq_rem",   rem_a,   52);
    check("a_shreq_empty", empty_a, 0);
    any_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      any_valid |= valid_a | busy_a;
      tick();
    end
    check("a_shreq_quiet", 32'(any_valid), 0);

    // ---- dut_b: 4 x 2, counter parked at (0,0) ----
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      expect_deal(1'b1, $sformatf("b_fill%0d", i), i % 4, i / 4, 2 + i, 7 - i);
      seen[int'(card_b) + 4 * int'(deck_b)] = 1'b1;
    end
    check("b_fill_unique", seen, 8'hFF);
    check("b_fill_empty",  empty_b, 1);

    deal(1'b1, c, d, l, bc, g, e);
    check("b_empty_err",     32'(e), 1);
    check("b_empty_novalid", 32'(g), 0);
    check("b_empty_err_lat", l, 1);
    tick();
    check("b_empty_err_once", err_b,   0);
    check("b_empty_rem",      rem_b,   0);
    check("b_empty_busy",     busy_b,  0);

    shuffle_b = 1'b1;
    tick();
    shuffle_b = 1'b0;
    check("b_shuf_rem",   rem_b,   8);
    check("b_shuf_empty", empty_b, 0);

    // Park the counter at (1,3) and deal the last slot, then wrap.
    run_cycles(1'b1, 7);
    expect_deal(1'b1, "b_last",  3, 1, 2, 7);
    expect_deal(1'b1, "b_wrap",  0, 0, 3, 6);
    expect_deal(1'b1, "b_skip2", 1, 0, 4, 5);

    // Abort: scan visits 7,0,1 (dealt) then reaches free slot 2; shuffle
    // arrives on the edge that would otherwise deal it.
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    check("b_abort_busy0", busy_b, 1);
    repeat (3) tick();
    check("b_abort_busy3",  busy_b,  1);
    check("b_abort_valid3", valid_b, 0);
    shuffle_b = 1'b1;
    tick();
    shuffle_b = 1'b0;
    check("b_abort_valid", valid_b, 0);
    check("b_abort_busy",  busy_b,  0);
    check("b_abort_rem",   rem_b,   8);
    check("b_abort_hold",  card_b,  1);
    any_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_valid |= valid_b | busy_b;
    end
    check("b_abort_quiet", 32'(any_valid), 0);

    // Asynchronous reset in the middle of a scan.
    expect_deal(1'b1, "b_prerst", 3, 1, 2, 7);
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    check("b_rst_scan_busy", busy_b, 1);
    #2 rst_n = 1'b0;
    #1;
    check("b_arst_card",  card_b,  0);
    check("b_arst_deck",  deck_b,  0);
    check("b_arst_valid", valid_b, 0);
    check("b_arst_busy",  busy_b,  0);
    check("b_arst_err",   err_b,   0);
    check("b_arst_empty", empty_b, 0);
    check("b_arst_rem",   rem_b,   8);
    check("a_arst_rem",   rem_a,   52);
    #3 rst_n = 1'b1;
    any_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_valid |= valid_b | busy_b;
    end
    check("b_postrst_quiet", 32'(any_valid), 0);
    expect_deal(1'b1, "b_postrst", 0, 0, 2, 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
